mc_cpu: RTL
===========

MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter DW, default 8, SHALL set the datapath/register width (legal 8..32).
REQ-002 Parameter PCW, default 8, SHALL set the program-counter and data-address width (legal 6..16).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  16  instruction word addressed by pc, sampled in FETCH.
REQ-006 pc  output  PCW  current program counter.
REQ-007 mem_req  output  1  data-memory request, held until accepted.
REQ-008 mem_we  output  1  1 = store, 0 = load; valid while mem_req=1.
REQ-009 mem_addr  output  PCW  R[SA][PCW-1:0], zero-extended if DW<PCW; valid while mem_req=1.
REQ-010 data_out  output  DW  store data R[SB]; valid while mem_req=1 and mem_we=1.
REQ-011 data_in  input  DW  load data; valid in the cycle mem_ready=1.
REQ-012 mem_ready  input  1  memory accepts or completes the current request.
REQ-013 halted  output  1  processor is in HALT.
REQ-014 dbg_sel  input  3 and dbg_data  output  DW  combinational read of R[dbg_sel].

Function
REQ-015 Field decode SHALL be: opcode=IR[15:9], DR=IR[8:6], SA=IR[5:3], SB=IR[2:0], IMM=IR[2:0] zero-extended to DW, OFF={IR[8:6],IR[2:0]} sign-extended to PCW.
REQ-016 FSM states SHALL be FETCH, EXEC, MEM and HALT.
REQ-017 FETCH: latch instr into IR, then go to EXEC; no architectural state other than IR changes.
REQ-018 EXEC, ALU ops SHALL write R[DR] and set pc=pc+1, then go to FETCH, for 2 cycles per instruction. The ops are:
- MOVA 0000000 SA; INC 0000001 SA+1; ADD 0000010 SA+SB; SUB 0000101 SA-SB; DEC 0000110 SA-1
- AND 0001000; OR 0001001; XOR 0001010; NOT 0001011 ~SA; MOVB 0001100 SB
- SHR 0001101 SB>>1, zero fill; SHL 0001110 SB<<1, zero fill
- LDI 1001100 IMM; ADI 1000010 SA+IMM
REQ-019 All arithmetic SHALL be modulo 2^DW; carries are discarded.
REQ-020 Branches:
- BRZ 1100000: pc=pc+OFF if R[SA]==0, else pc+1.
- BRN 1100001: pc=pc+OFF if R[SA][DW-1]==1, else pc+1.
- JMP 1110000: pc=R[SA][PCW-1:0].
- PC arithmetic SHALL wrap modulo 2^PCW.
REQ-021 LD 0010000 and ST 0100000: EXEC SHALL assert mem_req with mem_we set and go to MEM.
REQ-022 MEM: mem_req, mem_we, mem_addr and data_out SHALL stay stable until the cycle mem_ready=1. In that cycle:
- LD writes data_in to R[DR];
- pc=pc+1;
- mem_req drops on the next edge;
- go to FETCH.
REQ-023 mem_ready while mem_req=0 SHALL be ignored. mem_ready=1 on the first MEM cycle SHALL give 3-cycle LD/ST.
REQ-024 HALT 1111111 SHALL enter HALT, assert halted and freeze pc and registers until reset.
REQ-025 Any other opcode SHALL execute as NOP (pc=pc+1, no write).
REQ-026 Only one register write occurs per instruction. R0 SHALL be an ordinary writable register.

Reset
REQ-027 reset=1 at an edge SHALL set the following, overriding any state including MEM and HALT:
- state=FETCH, pc=0, IR=0, all registers 0;
- mem_req=0, mem_we=0, halted=0.
REQ-028 A pending memory request aborted by reset SHALL NOT write any register.

Structure
REQ-029 Package mc_cpu_pkg SHALL hold the opcode localparams, the FSM state enum and the ALU-function encoding.
REQ-030 The ALU SHALL be a single combinational sub-module, mc_cpu_alu, parametrised by DW. The register file, FSM and PC logic SHALL live in mc_cpu.

Verification
REQ-031 Program LDI R1,5; LDI R2,3; ADD R3,R1,R2; SUB R4,R2,R1 -> R3=8, R4=0xFE (DW=8); pc=4 after 8 cycles.
REQ-032 DW=16, DEC on R5=0 -> R5=0xFFFF. BRN R5 with OFF=-2 at pc=10 -> pc=8.
REQ-033 ST with R1=0x20, R2=0xAA and mem_ready delayed 3 cycles -> mem_req high for 4 cycles with mem_addr=0x20 and data_out=0xAA held stable; then pc+1.
REQ-034 LD R6 from 0x40 with data_in=0x5C on the ready cycle -> R6=0x5C; BRZ on R0=0 with OFF=+3 at pc=0xFE -> pc=0x01 (wrap).
REQ-035 reset asserted in MEM during an LD -> no register write, pc=0, mem_req=0 next cycle.
REQ-036 HALT at pc=7 -> halted=1, pc stays 7 for 20 cycles; reset -> halted=0, pc=0.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the mc_cpu multi-cycle processor: opcodes, FSM states,
// ALU function codes and the instruction-class decoder.
package mc_cpu_pkg;

  localparam logic [6:0] OP_MOVA = 7'b0000000;
  localparam logic [6:0] OP_INC  = 7'b0000001;
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101;
  localparam logic [6:0] OP_DEC  = 7'b0000110;
  localparam logic [6:0] OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001;
  localparam logic [6:0] OP_XOR  = 7'b0001010;
  localparam logic [6:0] OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_MOVB = 7'b0001100;
  localparam logic [6:0] OP_SHR  = 7'b0001101;
  localparam logic [6:0] OP_SHL  = 7'b0001110;
  localparam logic [6:0] OP_LDI  = 7'b1001100;
  localparam logic [6:0] OP_ADI  = 7'b1000010;
  localparam logic [6:0] OP_BRZ  = 7'b1100000;
  localparam logic [6:0] OP_BRN  = 7'b1100001;
  localparam logic [6:0] OP_JMP  = 7'b1110000;
  localparam logic [6:0] OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  typedef enum logic [3:0] {
    ALU_MOVA, ALU_INC, ALU_ADD, ALU_SUB, ALU_DEC, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOT, ALU_MOVB, ALU_SHR, ALU_SHL
  } alu_fn_e;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_BRZ, CL_BRN, CL_JMP, CL_MEM, CL_HALT
  } op_class_e;

  typedef struct packed {
    op_class_e cls;
    alu_fn_e   fn;
    logic      use_imm;
  } dec_t;

  // LDI and ADI reuse MOVB/ADD with the zero-extended immediate on the B input.
  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d.cls     = CL_ALU;
    d.fn      = ALU_MOVA;
    d.use_imm = 1'b0;
    case (op)
      OP_MOVA: d.fn = ALU_MOVA;
      OP_INC:  d.fn = ALU_INC;
      OP_ADD:  d.fn = ALU_ADD;
      OP_SUB:  d.fn = ALU_SUB;
      OP_DEC:  d.fn = ALU_DEC;
      OP_AND:  d.fn = ALU_AND;
      OP_OR:   d.fn = ALU_OR;
      OP_XOR:  d.fn = ALU_XOR;
      OP_NOT:  d.fn = ALU_NOT;
      OP_MOVB: d.fn = ALU_MOVB;
      OP_SHR:  d.fn = ALU_SHR;
      OP_SHL:  d.fn = ALU_SHL;
      OP_LDI:  begin d.fn = ALU_MOVB; d.use_imm = 1'b1; end
      OP_ADI:  begin d.fn = ALU_ADD;  d.use_imm = 1'b1; end
      OP_BRZ:  d.cls = CL_BRZ;
      OP_BRN:  d.cls = CL_BRN;
      OP_JMP:  d.cls = CL_JMP;
      OP_LD,
      OP_ST:   d.cls = CL_MEM;
      OP_HALT: d.cls = CL_HALT;
      default: d.cls = CL_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_cpu_if.sv
// Data-memory request/response bus between mc_cpu (master) and memory (slave).
interface mc_cpu_if #(
  parameter int DW  = 8,
  parameter int PCW = 8
);
  logic           mem_req;
  logic           mem_we;
  logic [PCW-1:0] mem_addr;
  logic [DW-1:0]  data_out;
  logic [DW-1:0]  data_in;
  logic           mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, data_out,
    input  data_in, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, data_out,
    output data_in, mem_ready
  );
endinterface

// File: rtl/mc_cpu_alu.sv
// Combinational ALU for mc_cpu; all arithmetic wraps modulo 2^DW.
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  alu_fn_e       fn,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (fn)
      ALU_MOVA: y = a;
      ALU_INC:  y = a + DW'(1);
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_DEC:  y = a - DW'(1);
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOT:  y = ~a;
      ALU_MOVB: y = b;
      ALU_SHR:  y = b >> 1;
      ALU_SHL:  y = b << 1;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle accumulator-less CPU: FETCH/EXEC/MEM/HALT FSM, 8-entry register
// file, PC logic and a stall-until-ready data-memory port.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    instr,
  output logic [PCW-1:0] pc,
  output logic           halted,
  input  logic [2:0]     dbg_sel,
  output logic [DW-1:0]  dbg_data,
  mc_cpu_if.master       bus
);

  state_e                state;
  logic [15:0]           ir;
  logic [DW-1:0]         rf [8];

  logic [6:0]            op;
  logic [2:0]            dr, sa, sb;
  dec_t                  dec;
  logic [DW-1:0]         ra, rb, imm, alu_b, alu_y;
  logic signed [5:0]     off6;
  logic signed [PCW-1:0] off_ext;
  logic [PCW-1:0]        pc_inc, pc_off, sa_addr;
  logic                  ra_zero, ra_neg;

  assign op      = ir[15:9];
  assign dr      = ir[8:6];
  assign sa      = ir[5:3];
  assign sb      = ir[2:0];
  assign dec     = decode(op);
  assign ra      = rf[sa];
  assign rb      = rf[sb];
  assign imm     = DW'(sb);
  assign alu_b   = dec.use_imm ? imm : rb;
  assign off6    = {dr, sb};
  assign off_ext = PCW'(off6);
  assign pc_inc  = pc + PCW'(1);
  assign pc_off  = pc + $unsigned(off_ext);
  assign ra_zero = (ra == '0);
  assign ra_neg  = ra[DW-1];

  assign dbg_data = rf[dbg_sel];

  // Register value used as an address: truncated or zero-extended to PCW.
  if (DW >= PCW) begin : g_addr_trunc
    assign sa_addr = ra[PCW-1:0];
  end else begin : g_addr_zext
    assign sa_addr = {{(PCW - DW){1'b0}}, ra};
  end

  mc_cpu_alu #(.DW(DW)) u_alu (
    .fn (dec.fn),
    .a  (ra),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= '0;
      ir          <= '0;
      halted      <= 1'b0;
      bus.mem_req <= 1'b0;
      bus.mem_we  <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= instr;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (dec.cls)
            CL_ALU: begin
              rf[dr] <= alu_y;
              pc     <= pc_inc;
            end
            CL_BRZ:  pc <= ra_zero ? pc_off : pc_inc;
            CL_BRN:  pc <= ra_neg ? pc_off : pc_inc;
            CL_JMP:  pc <= sa_addr;
            CL_MEM: begin
              bus.mem_req  <= 1'b1;
              bus.mem_we   <= (op == OP_ST);
              bus.mem_addr <= sa_addr;
              bus.data_out <= rb;
              state        <= MEM;
            end
            CL_HALT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: pc <= pc_inc;
          endcase
        end
        // Request fields are frozen here; only the ready cycle retires the access.
        MEM: begin
          if (bus.mem_ready) begin
            if (!bus.mem_we) rf[dr] <= bus.data_in;
            pc          <= pc_inc;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            state       <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
